// File: rtl/event_encoder8to3.sv
// rtl/event_encoder8to3.sv - 8-line event collector serving pending events as 3-bit codes (optional ROUND_ROBIN_EN)
module event_encoder8to3 #(
    parameter int EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [3:0] pend_cnt,
    output logic       overflow
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pending;
    logic [7:0] pending_next;
    logic [7:0] req_q;
    logic [7:0] ev;
    logic [7:0] grant;
    logic [2:0] sel_idx;
    logic       sel_found;
    logic [2:0] code_next;
    logic       valid_next;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // In edge mode only a 0->1 transition is an event; level mode treats every high cycle as one.
    assign ev = (EDGE_MODE != 0) ? (req & ~req_q) : req;

    // A bit being granted is cleared, but a fresh event on the same bit re-pends it.
    assign pending_next = (pending & ~grant) | ev;

    assign sel_found = |pending;

`ifdef ROUND_ROBIN_EN
    logic [2:0] last_grant;
    logic [2:0] search_start;
    logic [2:0] probe;

    assign search_start = last_grant + 3'd1;

    // Rotating search: scan from the bit after the last grant; descending loop lets the nearest bit win.
    always_comb begin
        sel_idx = 3'd0;
        probe   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            probe = search_start + 3'(k);
            if (pending[probe]) begin
                sel_idx = probe;
            end
        end
    end

    // Remember the most recent grant so the next search starts just past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 3'd7;
        end else if (|grant) begin
            last_grant <= sel_idx;
        end
    end
`else
    // Fixed priority: bit 0 highest; descending loop lets the lowest set bit win.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = 3'(i);
            end
        end
    end
`endif

    // Next-state, grant and output-register decode for the IDLE/PRESENT handshake.
    always_comb begin
        state_next = state;
        code_next  = code;
        valid_next = code_valid;
        grant      = 8'd0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant      = 8'd1 << sel_idx;
                    code_next  = sel_idx;
                    valid_next = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (code_valid && code_ready) begin
                    if (sel_found) begin
                        grant      = 8'd1 << sel_idx;
                        code_next  = sel_idx;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register state, outputs and the pending set; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 8'd0;
            req_q      <= 8'd0;
            code       <= 3'd0;
            code_valid <= 1'b0;
            overflow   <= 1'b0;
            pend_cnt   <= 4'd0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            req_q      <= req;
            code       <= code_next;
            code_valid <= valid_next;
            overflow   <= |(ev & pending & ~grant);
            pend_cnt   <= popcount8(pending_next);
        end
    end

endmodule

// File: tb/tb_event_encoder8to3.sv
// tb/tb_event_encoder8to3.sv - self-checking bench for event_encoder8to3, edge and level instances
module tb_event_encoder8to3;

    logic       clk;
    logic       rst;
    logic [7:0] req0, req1;
    logic       rdy0, rdy1;
    logic [2:0] code0, code1;
    logic       valid0, valid1;
    logic [3:0] cnt0, cnt1;
    logic       ovf0, ovf1;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] m_pend [2];
    logic [7:0] m_prev [2];
    int         m_code [2];
    int         m_valid[2];
    int         m_ovf  [2];
    int         m_cnt  [2];
    int         m_last [2];

    int exp_burst[3];
    int exp_lvl  [4];

    event_encoder8to3 #(.EDGE_MODE(1)) dut_edge (
        .clk(clk), .rst(rst), .req(req0), .code(code0), .code_valid(valid0),
        .code_ready(rdy0), .pend_cnt(cnt0), .overflow(ovf0)
    );

    event_encoder8to3 #(.EDGE_MODE(0)) dut_lvl (
        .clk(clk), .rst(rst), .req(req1), .code(code1), .code_valid(valid1),
        .code_ready(rdy1), .pend_cnt(cnt1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: a served slot opens whenever nothing is shown or the shown code is taken.
    task automatic model_step(input int u, input logic [7:0] r, input logic y, input logic rs);
        logic [7:0] ev;
        logic [7:0] g;
        int idx;
        int b;
        if (rs) begin
            m_pend[u] = 8'd0; m_prev[u] = 8'd0; m_code[u] = 0; m_valid[u] = 0;
            m_ovf[u] = 0; m_cnt[u] = 0; m_last[u] = 7;
        end else begin
            ev = (u == 0) ? (r & ~m_prev[u]) : r;
            g  = 8'd0;
            if (m_valid[u] == 0 || y) begin
                idx = -1;
                for (int k = 0; k < 8; k++) begin
`ifdef ROUND_ROBIN_EN
                    b = (m_last[u] + 1 + k) % 8;
`else
                    b = k;
`endif
                    if (idx < 0 && m_pend[u][b]) idx = b;
                end
                if (idx >= 0) begin
                    g[idx]    = 1'b1;
                    m_code[u] = idx;
                    m_valid[u] = 1;
                    m_last[u] = idx;
                end else begin
                    m_valid[u] = 0;
                end
            end
            m_ovf[u]  = ((ev & m_pend[u] & ~g) != 8'd0) ? 1 : 0;
            m_pend[u] = (m_pend[u] & ~g) | ev;
            m_cnt[u]  = $countones(m_pend[u]);
            m_prev[u] = r;
        end
    endtask

    task automatic compare_all();
        chk("edge.code",  int'(code0),  m_code[0]);
        chk("edge.valid", int'(valid0), m_valid[0]);
        chk("edge.cnt",   int'(cnt0),   m_cnt[0]);
        chk("edge.ovf",   int'(ovf0),   m_ovf[0]);
        chk("lvl.code",   int'(code1),  m_code[1]);
        chk("lvl.valid",  int'(valid1), m_valid[1]);
        chk("lvl.cnt",    int'(cnt1),   m_cnt[1]);
        chk("lvl.ovf",    int'(ovf1),   m_ovf[1]);
    endtask

    task automatic step(input logic [7:0] r0, input logic y0, input logic [7:0] r1,
                        input logic y1, input logic rs);
        req0 = r0; rdy0 = y0; req1 = r1; rdy1 = y1; rst = rs;
        @(posedge clk);
        model_step(0, r0, y0, rs);
        model_step(1, r1, y1, rs);
        #1;
        compare_all();
    endtask

    initial begin
`ifdef ROUND_ROBIN_EN
        exp_burst = '{7, 0, 4};
        exp_lvl   = '{0, 1, 0, 1};
`else
        exp_burst = '{0, 4, 7};
        exp_lvl   = '{0, 0, 0, 0};
`endif
        req0 = 8'd0; req1 = 8'd0; rdy0 = 1'b0; rdy1 = 1'b0; rst = 1'b1;

        // Reset with all lines high, then release: every line is one event.
        step(8'hFF, 1'b1, 8'h00, 1'b0, 1'b1);
        step(8'hFF, 1'b1, 8'h00, 1'b0, 1'b1);
        chk("rst.valid", int'(valid0), 0);
        chk("rst.cnt",   int'(cnt0),   0);
        chk("rst.ovf",   int'(ovf0),   0);
        step(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("rel.cnt8",  int'(cnt0),   8);
        chk("rel.valid", int'(valid0), 0);
        for (int i = 0; i < 8; i++) begin
            step(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
            chk("drain.code",  int'(code0),  i);
            chk("drain.valid", int'(valid0), 1);
        end
        step(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("drain.end", int'(valid0), 0);
        step(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

        // Single event on bit 5.
        step(8'h20, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("single.cnt1",  int'(cnt0),   1);
        chk("single.nval",  int'(valid0), 0);
        step(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("single.code",  int'(code0),  5);
        chk("single.valid", int'(valid0), 1);
        chk("single.cnt0",  int'(cnt0),   0);
        step(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("single.idle",  int'(valid0), 0);
        chk("single.hold",  int'(code0),  5);

        // Burst of three simultaneous edges.
        step(8'h91, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("burst.cnt", int'(cnt0), 3);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
            chk("burst.code", int'(code0), exp_burst[i]);
        end
        step(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("burst.end", int'(valid0), 0);

        // Backpressure: code 3 held while bit 1 arrives.
        step(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("bp.hold", int'(code0), 3);
        end
        step(8'h0A, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bp.code3", int'(code0), 3);
        chk("bp.cnt1",  int'(cnt0),  1);
        step(8'h0A, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("bp.next",  int'(code0), 1);
        step(8'h0A, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("bp.end",   int'(valid0), 0);

        // Overflow on a re-asserted pending bit, then the grant-cycle race.
        step(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ov.code0", int'(code0), 0);
        step(8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ov.cnt1", int'(cnt0), 1);
        step(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ov.pulse", int'(ovf0), 1);
        chk("ov.cnt",   int'(cnt0), 1);
        step(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ov.once",  int'(ovf0), 0);
        step(8'h05, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("race.ovf",  int'(ovf0),  0);
        chk("race.code", int'(code0), 2);
        chk("race.cnt",  int'(cnt0),  1);
        step(8'h01, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("race.again", int'(code0), 2);
        step(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("race.end", int'(valid0), 0);

        // Level mode with two lines held high.
        step(8'h00, 1'b1, 8'h03, 1'b1, 1'b0);
        chk("lvl.cnt2", int'(cnt1), 2);
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b1, 8'h03, 1'b1, 1'b0);
            chk("lvl.seq", int'(code1), exp_lvl[i]);
            chk("lvl.ovf", int'(ovf1), 1);
        end

        // Randomized traffic against the reference model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom_range(0, 255) & $urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
